multi_cycle_cpu: RTL and testbench

Parametrised multi-cycle MIPS-subset core: next generation of the team's single-cycle CPU. Each instruction runs through a fetch/decode/execute/memory/writeback state machine that shares one ALU, and talks to external instruction and data memories over a request/ready handshake that tolerates wait states. The core owns the PC, the register file and the halt/illegal status. It sits between the testbench memories and the debug/trace logic.

---
 rtl/mc_cpu_pkg.sv | 34 +++
 rtl/mc_regfile.sv | 27 ++
 rtl/multi_cycle_cpu.sv | 209 ++++++++++++++++++++
 tb/tb_multi_cycle_cpu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - opcodes, functs, FSM states and ALU ops for the multi-cycle core
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 32x32 register file, two async read ports, one sync write port, r0 hardwired to zero
module mc_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/multi_cycle_cpu.sv
// rtl/multi_cycle_cpu.sv - multi-cycle MIPS-subset core with shared ALU and req/ready memory ports
module multi_cycle_cpu
  import mc_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              illegal
);

  state_t      state, state_nx;
  logic [31:0] pc_r, ir, a_r, b_r, mdr, alu_out, target;
  logic        illegal_r;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm_sext = sext16(ir[15:0]);
  assign imm_zext = {16'd0, ir[15:0]};

  logic is_rtype, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_halt;
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_halt  = (opcode == OP_HALT);

  alu_op_t alu_op;
  logic    use_imm, use_zext, is_illegal;

  always_comb begin
    alu_op     = ALU_ADD;
    use_imm    = 1'b0;
    use_zext   = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_JR:   alu_op = ALU_ADD;
          default: is_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: use_imm = 1'b1;
      OP_SLTI: begin
        use_imm = 1'b1;
        alu_op  = ALU_SLT;
      end
      OP_ANDI: begin
        use_imm  = 1'b1;
        use_zext = 1'b1;
        alu_op   = ALU_AND;
      end
      OP_ORI: begin
        use_imm  = 1'b1;
        use_zext = 1'b1;
        alu_op   = ALU_OR;
      end
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_J, OP_JAL, OP_HALT: alu_op = ALU_ADD;
      default: is_illegal = 1'b1;
    endcase
  end

  logic [31:0] src_b, alu_res;
  assign src_b = use_imm ? (use_zext ? imm_zext : imm_sext) : b_r;

  always_comb begin
    alu_res = a_r + src_b;
    case (alu_op)
      ALU_SUB: alu_res = a_r - src_b;
      ALU_AND: alu_res = a_r & src_b;
      ALU_OR:  alu_res = a_r | src_b;
      ALU_SLT: alu_res = {31'd0, ($signed(a_r) < $signed(src_b))};
      ALU_SLL: alu_res = b_r << shamt;
      ALU_SRL: alu_res = b_r >> shamt;
      default: alu_res = a_r + src_b;
    endcase
  end

  logic [31:0] rf_a, rf_b, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_we;

  // jal links during DECODE; every other writer retires in WB
  assign rf_we    = ((state == DECODE) && is_jal) || (state == WB);
  assign rf_waddr = (state == DECODE) ? 5'd31 : (is_rtype ? rd : rt);
  assign rf_wdata = (state == DECODE) ? pc_r : (is_lw ? mdr : alu_out);

  mc_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  if (imem_ready) state_nx = DECODE;
      DECODE: begin
        if (is_j || is_jal)                              state_nx = FETCH;
        else if (is_halt || (is_illegal && HALT_ON_ILLEGAL)) state_nx = HALT;
        else if (is_illegal)                             state_nx = FETCH;
        else                                             state_nx = EXEC;
      end
      EXEC: begin
        if (is_beq || is_bne || is_jr) state_nx = FETCH;
        else if (is_lw || is_sw)       state_nx = MEM;
        else                           state_nx = WB;
      end
      MEM:     if (dmem_ready) state_nx = is_sw ? FETCH : WB;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= RESET_PC;
      ir        <= '0;
      a_r       <= '0;
      b_r       <= '0;
      mdr       <= '0;
      alu_out   <= '0;
      target    <= '0;
      illegal_r <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            ir   <= imem_rdata;
            pc_r <= pc_r + 32'd4;
          end
        end
        DECODE: begin
          a_r    <= rf_a;
          b_r    <= rf_b;
          target <= pc_r + {imm_sext[29:0], 2'b00};
          if (is_j || is_jal) pc_r <= {pc_r[31:28], ir[25:0], 2'b00};
          if (is_illegal)     illegal_r <= 1'b1;
        end
        EXEC: begin
          alu_out <= alu_res;
          if ((is_beq && (a_r == b_r)) || (is_bne && (a_r != b_r))) pc_r <= target;
          if (is_jr) pc_r <= a_r;
        end
        MEM: begin
          if (dmem_ready && is_lw) mdr <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc_r[ADDR_W-1:0];
  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && is_sw;
  assign dmem_addr  = alu_out[ADDR_W-1:0];
  assign dmem_wdata = b_r;
  assign pc         = pc_r;
  assign halted     = (state == HALT);
  assign illegal    = illegal_r;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb/tb_multi_cycle_cpu.sv - directed self-checking bench for multi_cycle_cpu
module tb_multi_cycle_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic        halted, illegal;

  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:255];
  int          dmem_wait = 0;
  int          dcnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  multi_cycle_cpu #(
    .RESET_PC        (32'h0000_0100),
    .ADDR_W          (32),
    .HALT_ON_ILLEGAL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  assign imem_rdata = imem[imem_addr[11:2]];
  assign dmem_rdata = dmem[dmem_addr[9:2]];
  assign dmem_ready = dmem_req && (dcnt == dmem_wait);

  always @(posedge clk) begin
    if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
    else                         dcnt <= 0;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input logic [31:0] addr, output int cycles);
    cycles = 0;
    while (!(imem_req && imem_addr == addr) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    n_cmp++;
    assert (imem_req && imem_addr == addr) else begin
      n_err++;
      $error("FAIL fetch_wait observed=%h expected=%h", imem_addr, addr);
    end
  endtask

  initial begin
    int c, reqc, bad;
    logic [31:0] acc;
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    dmem_wait  = 3;
    for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
    imem[64]  = 32'h0000_3020;  // 0x100 add  r6,r0,r0
    imem[65]  = 32'h2001_0005;  // 0x104 addi r1,r0,5
    imem[66]  = 32'h2002_FFFD;  // 0x108 addi r2,r0,-3
    imem[67]  = 32'h0022_1820;  // 0x10C add  r3,r1,r2
    imem[68]  = 32'h0041_202A;  // 0x110 slt  r4,r2,r1
    imem[69]  = 32'h2000_0007;  // 0x114 addi r0,r0,7
    imem[70]  = 32'h3407_8001;  // 0x118 ori  r7,r0,0x8001
    imem[71]  = 32'h0007_4100;  // 0x11C sll  r8,r7,4
    imem[72]  = 32'hAC03_0008;  // 0x120 sw   r3,8(r0)
    imem[73]  = 32'h8C05_0008;  // 0x124 lw   r5,8(r0)
    imem[74]  = 32'h0800_0008;  // 0x128 j    0x20
    imem[7]   = 32'h2006_0001;  // 0x1C  addi r6,r0,1
    imem[8]   = 32'h10C0_FFFE;  // 0x20  beq  r6,r0,-2
    imem[9]   = 32'h0800_0010;  // 0x24  j    0x40
    imem[16]  = 32'h0C00_0080;  // 0x40  jal  0x200
    imem[17]  = 32'h0000_003F;  // 0x44  illegal funct
    imem[18]  = 32'hFC00_0000;  // 0x48  halt
    imem[128] = 32'h03E0_0008;  // 0x200 jr   r31

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd1);
    chk("rst_imem_addr", imem_addr, 32'h100);
    chk("rst_pc", pc, 32'h100);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_flags", {30'd0, halted, illegal}, 32'd0);

    repeat (4) @(negedge clk);
    chk("add_next_fetch", imem_addr, 32'h104);

    wait_fetch(32'h120, c);
    chk("r0", dut.u_regfile.regs[0], 32'd0);
    chk("r1", dut.u_regfile.regs[1], 32'd5);
    chk("r2", dut.u_regfile.regs[2], 32'hFFFF_FFFD);
    chk("r3", dut.u_regfile.regs[3], 32'd2);
    chk("r4", dut.u_regfile.regs[4], 32'd1);
    chk("r7_ori", dut.u_regfile.regs[7], 32'h0000_8001);
    chk("r8_sll", dut.u_regfile.regs[8], 32'h0008_0010);

    c = 0; reqc = 0; bad = 0;
    do begin
      @(negedge clk);
      c++;
      if (dmem_req) begin
        reqc++;
        if (dmem_addr != 32'd8 || dmem_wdata != 32'd2 || !dmem_we) bad++;
      end
    end while (!(imem_req && imem_addr == 32'h124) && c < 50);
    chk("sw_cycles", c, 32'd7);
    chk("sw_req_cycles", reqc, 32'd4);
    chk("sw_hold_bad", bad, 32'd0);

    wait_fetch(32'h128, c);
    chk("lw_cycles", c, 32'd8);
    chk("r5_lw", dut.u_regfile.regs[5], 32'd2);
    chk("dmem_word2", dmem[2], 32'd2);

    wait_fetch(32'h20, c);
    chk("j_cycles", c, 32'd2);
    wait_fetch(32'h1C, c);
    chk("beq_taken_cycles", c, 32'd3);
    imem[8] = 32'h14C6_FFFE;    // 0x20 bne r6,r6,-2
    wait_fetch(32'h20, c);
    chk("r6_addi", dut.u_regfile.regs[6], 32'd1);
    wait_fetch(32'h24, c);
    chk("bne_not_taken_cycles", c, 32'd3);
    wait_fetch(32'h40, c);
    wait_fetch(32'h200, c);
    chk("jal_cycles", c, 32'd2);
    chk("r31_link", dut.u_regfile.regs[31], 32'h44);
    wait_fetch(32'h44, c);
    chk("jr_cycles", c, 32'd3);
    chk("illegal_before", {31'd0, illegal}, 32'd0);
    wait_fetch(32'h48, c);
    chk("illegal_nop_cycles", c, 32'd2);
    chk("illegal_sticky", {31'd0, illegal}, 32'd1);
    chk("not_halted_yet", {31'd0, halted}, 32'd0);

    repeat (2) @(negedge clk);
    chk("halted", {31'd0, halted}, 32'd1);
    reqc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req) reqc++;
    end
    chk("halt_no_req", reqc, 32'd0);
    chk("halt_pc", pc, 32'h4C);

    @(negedge clk);
    rst_n = 1'b0;
    imem[64] = 32'h0000_003F;   // 0x100 illegal funct
    imem[65] = 32'h2007_0009;   // 0x104 addi r7,r0,9
    imem[66] = 32'hAC07_000C;   // 0x108 sw   r7,12(r0)
    dmem_wait = 10;
    @(negedge clk);
    rst_n = 1'b1;
    wait_fetch(32'h108, c);
    chk("p2_cycles", c, 32'd6);
    c = 0;
    while (!dmem_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    chk("p2_in_mem_wait", {31'd0, dmem_req}, 32'd1);
    chk("p2_r7", dut.u_regfile.regs[7], 32'd9);
    chk("p2_illegal", {31'd0, illegal}, 32'd1);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", {30'd0, dmem_req, dmem_we}, 32'd0);
    chk("arst_imem_req", {31'd0, imem_req}, 32'd1);
    chk("arst_pc", pc, 32'h100);
    chk("arst_flags", {30'd0, halted, illegal}, 32'd0);
    acc = 32'd0;
    for (int i = 0; i < 32; i++) acc = acc | dut.u_regfile.regs[i];
    chk("arst_gprs", acc, 32'd0);
    chk("arst_ir_a_b_mdr", dut.ir | dut.a_r | dut.b_r | dut.mdr, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerelease_addr", imem_addr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
